// File: rtl/multiplier_async_pkg.sv
// Shared definitions for the multiply-accumulate / divide / exponentiation family:
// the common operation state encoding and the default operand width.
package multiplier_async_pkg;

   localparam int DEFAULT_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } op_state_e;

   // Iteration counter width able to hold the value WIDTH without wrapping.
   function automatic int cnt_width(input int w);
      return $clog2(w) + 1;
   endfunction

endpackage

// File: rtl/multiplier_async.sv
// Sequential radix-2 shift-add multiply-accumulate: product = A*B + C, one multiplier
// bit per cycle (LSB first), fixed WIDTH-cycle latency, single-operation-per-start handshake.
module multiplier_async
   import multiplier_async_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     addend,
   input  logic                 start,
   output logic [2*WIDTH-1:0]   product,
   output logic                 ready
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   op_state_e        state_r;
   op_state_e        next_state_s;
   logic [PW-1:0]    mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [PW-1:0]    acc_r;
   logic [CW-1:0]    cnt_r;
   logic [PW-1:0]    product_r;
   logic [PW-1:0]    partial_s;
   logic [PW-1:0]    sum_s;
   logic             load_s;
   logic             step_s;
   logic             last_s;
   logic             ready_s;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; DONE waits for start to drop so a held level runs only once.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               next_state_s = BUSY;
            end else begin
               next_state_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == LAST_CNT) begin
               next_state_s = DONE;
            end else begin
               next_state_s = BUSY;
            end
         end
         DONE: begin
            if (start) begin
               next_state_s = DONE;
            end else begin
               next_state_s = IDLE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Output and datapath-control decode; ready depends on state only.
   always_comb begin
      load_s  = 1'b0;
      step_s  = 1'b0;
      last_s  = 1'b0;
      ready_s = 1'b1;
      case (state_r)
         IDLE: begin
            load_s  = start;
            ready_s = 1'b1;
         end
         BUSY: begin
            step_s  = 1'b1;
            ready_s = 1'b0;
            if (cnt_r == LAST_CNT) begin
               last_s = 1'b1;
            end else begin
               last_s = 1'b0;
            end
         end
         DONE: begin
            ready_s = 1'b1;
         end
         default: begin
            ready_s = 1'b1;
         end
      endcase
   end

   // Partial product for the current multiplier bit and the running sum.
   always_comb begin
      if (mplier_r[0]) begin
         partial_s = mcand_r;
      end else begin
         partial_s = {PW{1'b0}};
      end
      sum_s = acc_r + partial_s;
   end

   // Shift-add datapath: capture loads C into the accumulator, each BUSY cycle consumes one bit of B.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mcand_r  <= {PW{1'b0}};
         mplier_r <= {WIDTH{1'b0}};
         acc_r    <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else if (load_s) begin
         mcand_r  <= {{WIDTH{1'b0}}, multiplicand};
         mplier_r <= multiplier;
         acc_r    <= {{WIDTH{1'b0}}, addend};
         cnt_r    <= {CW{1'b0}};
      end else if (step_s) begin
         mcand_r  <= mcand_r << 1;
         mplier_r <= mplier_r >> 1;
         acc_r    <= sum_s;
         if (!last_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   // Result register: written only with the final sum so partial sums never leak out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         product_r <= {PW{1'b0}};
      end else if (last_s) begin
         product_r <= sum_s;
      end
   end

   assign product = product_r;
   assign ready   = ready_s;

endmodule
